sprite_draw_scheduler: RTL
==========================

SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10'd600, WAIT-state cycles allowed before a grant is forcibly revoked.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 req  in  3  per-drawer draw request (bit i = drawer i: 0 hook, 1 poro, 2 player); level or pulse.
REQ-005 drw_done  in  3  per-drawer one-cycle completion pulse.
REQ-006 drw_x0/drw_x1/drw_x2  in  9 each  drawer pixel x.
REQ-007 drw_y0/drw_y1/drw_y2  in  8 each  drawer pixel y.
REQ-008 drw_c0/drw_c1/drw_c2  in  3 each  drawer pixel colour.
REQ-009 drw_we  in  3  per-drawer write enable.
REQ-010 plot  out  3  one-hot, one-cycle start pulse to the granted drawer.
REQ-011 grant  out  3  one-hot current owner of the VGA write port; 0 when idle.
REQ-012 x_out  out  9;  y_out  out  8;  colour_out  out  3;  writeEn  out  1  to the VGA adapter.
REQ-013 ack  out  3  one-cycle pulse on bit i when drawer i's job ends (done or timeout).
REQ-014 timeout_err  out  1  one-cycle pulse coincident with ack on a timed-out job.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Pending register pend[2:0]: bit i set on any cycle req[i]=1; cleared in RELEASE for the granted index unless req[i]=1 in that same cycle (set wins).
REQ-017 States: IDLE, ISSUE, WAIT, RELEASE; encoded, registered, one state per cycle except WAIT.
REQ-018 IDLE: if pend!=0, select winner by round-robin, load grant, go ISSUE; else stay. A req arriving in IDLE is granted no earlier than the cycle after it is registered in pend.
REQ-019 Round-robin: pointer ptr (0..2), reset 0; search order ptr, ptr+1, ptr+2 mod 3; after RELEASE of index i, ptr = (i+1) mod 3.
REQ-020 ISSUE: plot = grant for exactly this cycle; go WAIT.
REQ-021 WAIT: wait counter starts at 0 on entry, +1 per cycle; leave to RELEASE when drw_done[granted]=1 or counter = TIMEOUT_CYC-1, whichever first; done wins if both.
REQ-022 drw_done from non-granted drawers and drw_we from non-granted drawers are ignored.
REQ-023 RELEASE: ack = grant; timeout_err = 1 if exited by timeout; grant cleared at end of cycle; go IDLE.
REQ-024 Pixel forwarding registered, latency 1: if state=WAIT in cycle t, outputs in t+1 = granted drawer's x/y/colour/we; else writeEn=0 and x_out, y_out, colour_out = 0 in t+1.
REQ-025 A pixel written by the drawer in the cycle it asserts done is forwarded (appears on outputs in RELEASE).
REQ-026 Only one drawer granted at any time; grant never changes outside IDLE->ISSUE and RELEASE->IDLE.
REQ-027 Drawer with y=0 completing immediately (done 2 cycles after plot) is handled as a normal completion with zero writes.

Reset
REQ-028 resetn=0 at any time, including mid-WAIT: state=IDLE, pend=0, ptr=0, wait counter=0, grant=0, plot=0, ack=0, timeout_err=0, busy=0, writeEn=0, x_out=0, y_out=0, colour_out=0, immediately and without clock.
REQ-029 After resetn rises, first grant possible on the second rising edge at which req is high.

Verification
REQ-030 req=3'b001 pulse, drawer 0 writes 256 pixels then done -> plot[0] one cycle, 256 writeEn cycles with x/y equal to drawer values delayed 1 cycle, ack=3'b001, ptr=1.
REQ-031 req=3'b111 held one cycle from reset -> grant order 0,1,2, each ack before next plot, no overlapping writeEn sources.
REQ-032 Drawer 1 granted, never asserts done -> RELEASE after 600 WAIT cycles, ack=3'b010, timeout_err=1, then next pending drawer served.
REQ-033 Drawer 2 asserts drw_we and drw_done while drawer 0 is granted -> no writeEn from drawer 2, grant unchanged.
REQ-034 resetn pulsed low mid-WAIT of drawer 0 -> all outputs 0 asynchronously; drawer 0 not re-granted without a new req.
REQ-035 req[0] reasserted in drawer 0's RELEASE cycle -> pend[0] stays set; drawer 0 served again after drawers 1,2 if they are pending.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - round-robin arbiter granting three sprite drawers the VGA write port
module sprite_draw_scheduler #(
  parameter logic [9:0] TIMEOUT_CYC = 10'd600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] drw_done,
  input  logic [8:0] drw_x0,
  input  logic [8:0] drw_x1,
  input  logic [8:0] drw_x2,
  input  logic [7:0] drw_y0,
  input  logic [7:0] drw_y1,
  input  logic [7:0] drw_y2,
  input  logic [2:0] drw_c0,
  input  logic [2:0] drw_c1,
  input  logic [2:0] drw_c2,
  input  logic [2:0] drw_we,
  output logic [2:0] plot,
  output logic [2:0] grant,
  output logic [8:0] x_out,
  output logic [7:0] y_out,
  output logic [2:0] colour_out,
  output logic       writeEn,
  output logic [2:0] ack,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_e;

  state_e     state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [9:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic [8:0] x_q;
  logic [7:0] y_q;
  logic [2:0] c_q;
  logic       we_q;

  logic [1:0] win;
  logic       found;
  logic [2:0] cand;
  logic [8:0] sel_x;
  logic [7:0] sel_y;
  logic [2:0] sel_c;
  logic       sel_we;
  logic       sel_done;

  // Round-robin search starting at ptr_q, wrapping modulo 3.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && pend_q[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  // Only the granted drawer's pixel and done are ever looked at.
  always_comb begin
    sel_x = drw_x2; sel_y = drw_y2; sel_c = drw_c2;
    sel_we = drw_we[2]; sel_done = drw_done[2];
    case (idx_q)
      2'd0: begin
        sel_x = drw_x0; sel_y = drw_y0; sel_c = drw_c0;
        sel_we = drw_we[0]; sel_done = drw_done[0];
      end
      2'd1: begin
        sel_x = drw_x1; sel_y = drw_y1; sel_c = drw_c1;
        sel_we = drw_we[1]; sel_done = drw_done[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    // A request in the release cycle keeps the pending bit alive.
    pend_d  = (pend_q & ~((state_q == S_RELEASE) ? grant_q : 3'b000)) | req;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = 3'b001 << win;
          idx_d   = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 10'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          to_d    = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == TIMEOUT_CYC - 10'd1) begin
          to_d    = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_RELEASE: begin
        grant_d = 3'b000;
        ptr_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        cnt_d   = 10'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pend_q  <= 3'b000;
      grant_q <= 3'b000;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 10'd0;
      to_q    <= 1'b0;
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      c_q     <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      if (state_q == S_WAIT) begin
        x_q  <= sel_x;
        y_q  <= sel_y;
        c_q  <= sel_c;
        we_q <= sel_we;
      end else begin
        x_q  <= 9'd0;
        y_q  <= 8'd0;
        c_q  <= 3'd0;
        we_q <= 1'b0;
      end
    end
  end

  assign grant       = grant_q;
  assign plot        = (state_q == S_ISSUE)   ? grant_q : 3'b000;
  assign ack         = (state_q == S_RELEASE) ? grant_q : 3'b000;
  assign timeout_err = (state_q == S_RELEASE) && to_q;
  assign busy        = (state_q != S_IDLE);
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign colour_out  = c_q;
  assign writeEn     = we_q;

endmodule
